led_row_scanner: RTL
====================

# led_row_scanner

Time-multiplexed row scanner for the 8x8 LED array. Holds a double-buffered 8x8 frame, cycles a 3-bit row index through rows 0..7 at a programmable dwell rate, and drives the matching 8-bit column pattern with a blanking gap at the start of each row slot. ROW_SEL feeds the array's 3:8 row decoder, and COL drives the column lines. Game logic writes the back buffer and requests a swap, which takes effect only at a frame boundary, so the displayed frame never tears.

## Interface
- DIV, 1000: clock cycles per row slot; legal range is 2 or more.
- BLANK, 2: blank cycles at the start of each row slot; legal range is 1 <= BLANK < DIV.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; synchronous, active-high.
- WR_EN  in  1  write WR_DATA into row WR_ROW of the back buffer.
- WR_ROW  in  3  row address for the write.
- WR_DATA  in  8  column pattern; bit i drives column i, active-high.
- SWAP_REQ  in  1  request a front/back exchange at the next frame end; single-cycle pulse or level are both accepted.
- SWAP_PENDING  out  1  a swap request is latched and waiting for the frame end.
- ROW_SEL  out  3  current row index, to the row decoder.
- COL  out  8  column data for the current row; 0x00 while blanking.
- ROW_EN  out  1  high when COL carries row data (not blanking).
- FRAME_START  out  1  high on cycle 0 of row 0's slot.

## Operation
- State:
  - CNT, the dwell counter, counts 0..DIV-1.
  - ROW, 3 bits.
  - SEL, 1 bit; the front buffer is buf[SEL] and the back buffer is buf[~SEL].
  - Two 8x8 buffers.
  - PEND, 1 bit.
- Counting:
  - Each cycle, CNT increments.
  - When CNT==DIV-1, CNT returns to 0 and ROW increments.
  - ROW wraps from 7 to 0.
  - Frame end is defined as CNT==DIV-1 && ROW==7.
- Outputs are combinational decodes of registered state only; there is no input-to-output path.
  - ROW_SEL = ROW.
  - ROW_EN = (CNT >= BLANK).
  - COL = ROW_EN ? buf[SEL][ROW] : 0x00.
  - FRAME_START = (ROW==0 && CNT==0).
  - SWAP_PENDING = PEND.
- Writes:
  - When WR_EN=1, buf[~SEL][WR_ROW] <= WR_DATA at the clock edge, using the pre-edge SEL.
  - Writes are always accepted; no backpressure.
- Swap:
  - At frame end, if (PEND | SWAP_REQ) is set, SEL toggles and PEND clears.
  - Otherwise, SWAP_REQ=1 sets PEND.
  - SWAP_REQ while PEND=1 has no extra effect; requests do not queue.
- Simultaneous write and swap in the frame-end cycle:
  - The write lands in the pre-edge back buffer.
  - That buffer becomes the front buffer, so the written data is displayed from the next frame.
- Reset is synchronous and may assert at any point mid-frame. It takes effect at the next edge:
  - CNT=0, ROW=0, SEL=0, PEND=0.
  - Both buffers are cleared to 0x00.
  - A WR_EN or SWAP_REQ in the same cycle as RESET is ignored.

## Timing
- Output values during and immediately after reset:
  - ROW_SEL=0, COL=0x00, ROW_EN=0, SWAP_PENDING=0.
  - FRAME_START=1, since ROW=0 and CNT=0.
- With cycle k counted from the first cycle after RESET deasserts:
  - CNT = k mod DIV.
  - ROW = floor(k/DIV) mod 8.
  - Frame period is 8*DIV cycles.
- In each row slot:
  - COL is 0x00 for the first BLANK cycles.
  - COL then shows the row pattern for DIV-BLANK cycles.
- ROW_SEL and COL change on the same edge. Blanking covers the decoder's row-switch transient.
- Write-to-display latency:
  - A write lands in the back buffer only.
  - It becomes visible on the first displayed slot of that row after the next completed swap.
- Swap latency:
  - The new SEL is active from the first cycle of the next frame, when FRAME_START=1.
  - SWAP_PENDING rises one cycle after a non-frame-end SWAP_REQ and falls on the frame-end edge.

## Test plan
- Reset, DIV=4, BLANK=1: hold RESET for 3 cycles, then release -> ROW_SEL=0, COL=0x00, ROW_EN=0, FRAME_START=1, SWAP_PENDING=0; FRAME_START is 1 again at k=32 and 0 elsewhere.
- Scan order, DIV=4, BLANK=1: free-run 40 cycles -> ROW_SEL steps 0..7 every 4 cycles and wraps to 0 at k=32; ROW_EN pattern is 0,1,1,1 in every slot.
- Back-buffer isolation and mid-frame swap:
  - At k=2, write row 3 = 0xA5 and pulse SWAP_REQ.
  - COL during row 3 of frame 0 (k=12..15) stays 0x00.
  - SWAP_PENDING is 1 from k=3 through k=31, then 0.
  - In frame 1, COL at k=44 is 0x00 and at k=45..47 is 0xA5.
- Frame-end swap with simultaneous write:
  - At k=31, pulse SWAP_REQ with a write of row 0 = 0x3C.
  - SWAP_PENDING never rises.
  - COL at k=33..35 is 0x3C.
- Repeated requests: pulse SWAP_REQ at k=5 and k=9 -> exactly one toggle at k=31; nothing is pending afterwards; frame 2 shows the same buffer as frame 1.
- Reset mid-operation:
  - Load both buffers, swap, then assert RESET at k=50 for 1 cycle.
  - The next cycle has ROW_SEL=0 and CNT restarted.
  - COL stays 0x00 across a full frame; the buffers were cleared.

Source files
------------

// File: rtl/led_row_scanner.sv
// led_row_scanner: time-multiplexed 8x8 LED row scanner with a double-buffered frame.
// Latency: outputs decode registered state only. A write reaches the display after the next frame-end swap.
// Backpressure: none. Writes and swap requests are always accepted. Repeated swap requests do not queue.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_wr_en        write i_wr_data into row i_wr_row of the back buffer
//   i_wr_row       row address for the write
//   i_wr_data      column pattern; bit i drives column i, active-high
//   i_swap_req     request a front/back exchange at the next frame end (pulse or level)
//   o_swap_pending a swap request is latched and waiting for the frame end
//   o_row_sel      current row index, to the 3:8 row decoder
//   o_col          column data for the current row; 0x00 while blanking
//   o_row_en       high when o_col carries row data
//   o_frame_start  high on cycle 0 of row 0's slot
module led_row_scanner #(
  parameter int unsigned DIV   = 1000,  // clock cycles per row slot, >= 2
  parameter int unsigned BLANK = 2      // blank cycles at the start of each slot, 1..DIV-1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_row,
  input  logic [7:0] i_wr_data,
  input  logic       i_swap_req,
  output logic       o_swap_pending,
  output logic [2:0] o_row_sel,
  output logic [7:0] o_col,
  output logic       o_row_en,
  output logic       o_frame_start
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  // Dwell counter within the current row slot.
  logic [CNT_W-1:0] r_cnt;
  // Row currently being driven.
  logic [2:0]       r_row;
  // Front buffer select: r_buf[r_sel] is displayed, r_buf[~r_sel] is written.
  logic             r_sel;
  // A swap request is waiting for the frame end.
  logic             r_pend;
  // Two frame buffers, indexed [buffer][row] giving an 8-bit column pattern.
  logic [1:0][7:0][7:0] r_buf;

  logic w_cnt_last;
  logic w_frame_end;
  logic w_do_swap;
  logic w_back;

  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_last && (r_row == 3'd7);
  // A request arriving on the frame-end cycle itself swaps immediately.
  // It is never latched into r_pend.
  assign w_do_swap   = w_frame_end && (r_pend || i_swap_req);
  assign w_back      = ~r_sel;

  // Dwell counter and row index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_row <= 3'd0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_row <= r_row + 3'd1;  // wraps 7 -> 0 naturally
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Buffer select and the pending-swap flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel  <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_frame_end) begin
      if (w_do_swap) begin
        r_sel <= ~r_sel;
      end
      r_pend <= 1'b0;
    end else if (i_swap_req) begin
      r_pend <= 1'b1;
    end
  end

  // Back-buffer writes use the pre-edge select. A write on the swap edge
  // lands in the buffer that is about to become the front, so it shows
  // from the very next frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf <= '0;
    end else if (i_wr_en) begin
      r_buf[w_back][i_wr_row] <= i_wr_data;
    end
  end

  // Output decode. The blanking window hides the row decoder's switching
  // transient, because o_row_sel and o_col change on the same edge.
  assign o_row_sel      = r_row;
  assign o_row_en       = (r_cnt >= CNT_BLANK);
  assign o_col          = o_row_en ? r_buf[r_sel][r_row] : 8'h00;
  assign o_frame_start  = (r_row == 3'd0) && (r_cnt == '0);
  assign o_swap_pending = r_pend;

endmodule
